// File: rtl/dut_decoder.sv
// Receive-side inverse of the dut bit transform: decodes 10-bit words plus side key into 20-bit source words and buffers them in a small FIFO.
// Optional feature: define DEC_PARITY_EN to add the in_par port and drop words that fail even parity.
module dut_decoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [9:0]       in_word,
    input  logic [1:0]       in_key,
`ifdef DEC_PARITY_EN
    input  logic             in_par,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [19:0]      out_word,
    output logic [CNT_W-1:0] fmt_err_cnt,
    output logic [CNT_W-1:0] par_err_cnt
);

    // Handshakes: a word transfers on a rising edge where valid && ready;
    // valid must not depend on ready, and ready here depends only on state.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

    logic [19:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] fmt_cnt_q, fmt_cnt_d;

    logic        accept;
    logic        push;
    logic        pop;
    logic        par_bad;
    logic        fmt_bad;
    logic [19:0] dec_word;

    assign in_ready  = (count_q < DEPTH_OCC);
    assign out_valid = (count_q != '0);
    assign out_word  = mem_q[rd_ptr_q];

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;
    assign fmt_bad = (in_word[9:6] != 4'b0000);

`ifdef DEC_PARITY_EN
    logic [CNT_W-1:0] par_cnt_q, par_cnt_d;
    assign par_bad     = ^{in_par, in_key, in_word};
    assign par_err_cnt = par_cnt_q;
`else
    assign par_bad     = 1'b0;
    assign par_err_cnt = '0;
`endif

    assign push = accept && !par_bad;

    always_comb begin
        dec_word      = '0;
        dec_word[2:1] = in_word[1:0] ^ in_key;
        dec_word[4:3] = in_key;
        dec_word[8:5] = ~in_word[5:2];
    end

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        fmt_cnt_d = fmt_cnt_q;

        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase

        // Dropped parity words never reach the format check.
        if (push && fmt_bad && (fmt_cnt_q != '1)) begin
            fmt_cnt_d = fmt_cnt_q + CNT_W'(1);
        end
    end

`ifdef DEC_PARITY_EN
    always_comb begin
        par_cnt_d = par_cnt_q;
        if (accept && par_bad && (par_cnt_q != '1)) begin
            par_cnt_d = par_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            par_cnt_q <= '0;
        end else begin
            par_cnt_q <= par_cnt_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            fmt_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            fmt_cnt_q <= fmt_cnt_d;
            if (push) begin
                mem_q[wr_ptr_q] <= dec_word;
            end
        end
    end

    assign fmt_err_cnt = fmt_cnt_q;

endmodule
